// File: rtl/mc_contr_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU codes, datapath select encodings and the FSM state type.
package mc_contr_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] B_RT     = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BTA = 2'b01;
  localparam logic [1:0] PC_JTA = 2'b10;
  localparam logic [1:0] PC_EXC = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
`ifdef MC_CONTR_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} aluop_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: selects add, sub or a funct-derived operation and flags
// funct codes outside the supported R-type set.
module mc_aludec
  import mc_contr_pkg::*;
#(
  parameter int ALU_C_W = 4
) (
  input  aluop_t             aluop,
  input  logic [5:0]         funct,
  output logic [ALU_C_W-1:0] alu_c,
  output logic               illegal
);

  logic [3:0] code;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      AOP_SUB: code = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_c = ALU_C_W'(code);

endmodule

// File: rtl/mc_contr.sv
// Multicycle MIPS controller with ready-based memory handshake and timeout.
// Optional illegal-instruction trap enabled by MC_CONTR_ILLEGAL_TRAP_EN.
module mc_contr
  import mc_contr_pkg::*;
#(
  parameter int ALU_C_W     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op_c,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord_c,
  output logic               mw_c,
  output logic               ir_we_c,
  output logic               argA_c,
  output logic [1:0]         argB_c,
  output logic               dest_reg_c,
  output logic               result_c,
  output logic               we_c,
  output logic               pc_we_c,
  output logic [1:0]         pc_next_c,
  output logic [ALU_C_W-1:0] alu_c,
  output logic               instr_done,
  output logic               bus_err,
  output logic               exc_c
);

  state_t             state;
  logic [7:0]         wait_cnt;
  logic               in_mem, timeout, alu_en, fn_illegal;
  aluop_t             aluop;
  logic [ALU_C_W-1:0] alu_raw;

  mc_aludec #(.ALU_C_W(ALU_C_W)) u_aludec (
    .aluop   (aluop),
    .funct   (funct),
    .alu_c   (alu_raw),
    .illegal (fn_illegal)
  );

`ifndef MC_CONTR_ILLEGAL_TRAP_EN
  logic unused_fn_illegal;
  assign unused_fn_illegal = fn_illegal;
`endif

  assign in_mem  = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign timeout = in_mem && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      // The counter only runs while a memory state is stalled; any exit clears it.
      wait_cnt <= (in_mem && !mem_ready && !timeout) ? wait_cnt + 8'd1 : '0;
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op_c)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
`ifdef MC_CONTR_ILLEGAL_TRAP_EN
            default:      state <= S_TRAP;
`else
            default:      state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR: state <= (op_c == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (mem_ready)    state <= S_MEMWB;
          else if (timeout) state <= S_FETCH;
        end
        S_MEMWR:  if (mem_ready || timeout) state <= S_FETCH;
`ifdef MC_CONTR_ILLEGAL_TRAP_EN
        S_EXEC:   state <= fn_illegal ? S_TRAP : S_ALUWB;
`else
        S_EXEC:   state <= S_ALUWB;
`endif
        S_ADDIEX: state <= S_ADDIWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    iord_c     = 1'b0;
    mw_c       = 1'b0;
    ir_we_c    = 1'b0;
    argA_c     = 1'b0;
    argB_c     = B_RT;
    dest_reg_c = 1'b0;
    result_c   = 1'b0;
    we_c       = 1'b0;
    pc_we_c    = 1'b0;
    pc_next_c  = PC_ALU;
    aluop      = AOP_ADD;
    alu_en     = 1'b0;
    instr_done = 1'b0;
    bus_err    = 1'b0;
    exc_c      = 1'b0;
    if (!rst) begin
      bus_err = timeout;
      case (state)
        S_FETCH: begin
          mem_req = 1'b1; argB_c = B_FOUR; alu_en = 1'b1;
          ir_we_c = mem_ready; pc_we_c = mem_ready;
        end
        S_DECODE: begin
          argB_c = B_IMM_SH; alu_en = 1'b1;
`ifndef MC_CONTR_ILLEGAL_TRAP_EN
          instr_done = !is_known_op(op_c);
`endif
        end
        S_MEMADR: begin argA_c = 1'b1; argB_c = B_IMM; alu_en = 1'b1; end
        S_MEMRD:  begin mem_req = 1'b1; iord_c = 1'b1; end
        S_MEMWB:  begin we_c = 1'b1; result_c = 1'b1; instr_done = 1'b1; end
        S_MEMWR: begin
          mem_req = 1'b1; iord_c = 1'b1; mw_c = 1'b1; instr_done = mem_ready;
        end
        S_EXEC:   begin argA_c = 1'b1; aluop = AOP_FUNCT; alu_en = 1'b1; end
        S_ALUWB:  begin we_c = 1'b1; dest_reg_c = 1'b1; instr_done = 1'b1; end
        S_BRANCH: begin
          argA_c = 1'b1; aluop = AOP_SUB; alu_en = 1'b1;
          pc_next_c = PC_BTA; pc_we_c = zero; instr_done = 1'b1;
        end
        S_ADDIEX: begin argA_c = 1'b1; argB_c = B_IMM; alu_en = 1'b1; end
        S_ADDIWB: begin we_c = 1'b1; instr_done = 1'b1; end
        S_JUMP:   begin pc_next_c = PC_JTA; pc_we_c = 1'b1; instr_done = 1'b1; end
`ifdef MC_CONTR_ILLEGAL_TRAP_EN
        S_TRAP: begin
          exc_c = 1'b1; pc_we_c = 1'b1; pc_next_c = PC_EXC; instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign alu_c = alu_en ? alu_raw : '0;

endmodule
